// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, the canonical NOP, the default reset
// vector and the IF/ID pipeline register layout.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            fault;
  } if_id_t;

  function automatic if_id_t bubble();
    if_id_t b;
    b.valid = 1'b0;
    b.pc    = '0;
    b.instr = NOP_INSTR;
    b.fault = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter with next-PC selection: reset, redirect, stall hold or PC+4.
// Also tracks whether the current PC came from a misaligned redirect target.
module pc_reg
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc,
  output logic            misalign
);

  logic [XLEN-1:0] pc_next;
  logic            misalign_next;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    pc_next       = pc + XLEN'(4);
    misalign_next = 1'b0;
    if (redirect_valid) begin
      pc_next       = {redirect_pc[XLEN-1:2], 2'b00};
      misalign_next = |redirect_pc[1:0];
    end else if (stall) begin
      pc_next       = pc;
      misalign_next = misalign;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      misalign <= 1'b0;
    end else begin
      pc       <= pc_next;
      misalign <= misalign_next;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: drives the external instruction memory from the PC,
// captures the returned word into the IF/ID register and keeps fetch/stall counts.
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              IMEM_AW  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [XLEN-1:0] imem_instr_i,
  output logic            if_id_valid_o,
  output logic [XLEN-1:0] if_id_pc_o,
  output logic [XLEN-1:0] if_id_instr_o,
  output logic            if_id_fault_o,
  output logic [XLEN-1:0] fetch_cnt_o,
  output logic [XLEN-1:0] stall_cnt_o
);

  logic [XLEN-1:0] pc;
  logic            misalign;
  logic [XLEN-1:0] pc_high;
  logic            out_of_range;
  logic            kill;
  logic            capture;
  if_id_t          if_id_q;
  if_id_t          fetched;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall_i),
    .redirect_valid(redirect_valid_i),
    .redirect_pc   (redirect_pc_i),
    .pc            (pc),
    .misalign      (misalign)
  );

  assign imem_addr_o = pc;

  // Any PC bit above the word-address field points outside the instruction memory.
  assign pc_high      = pc >> (IMEM_AW + 2);
  assign out_of_range = |pc_high;

  assign kill    = flush_i | redirect_valid_i;
  assign capture = !kill && !stall_i;

  always_comb begin
    fetched.valid = 1'b1;
    fetched.pc    = pc;
    fetched.instr = out_of_range ? NOP_INSTR : imem_instr_i;
    fetched.fault = misalign | out_of_range;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_q     <= bubble();
      fetch_cnt_o <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (kill) begin
        if_id_q <= bubble();
      end else if (capture) begin
        if_id_q     <= fetched;
        fetch_cnt_o <= fetch_cnt_o + XLEN'(1);
      end
      // Only stalls that actually freeze the stage are counted.
      if (stall_i && !kill) begin
        stall_cnt_o <= stall_cnt_o + XLEN'(1);
      end
    end
  end

  assign if_id_valid_o = if_id_q.valid;
  assign if_id_pc_o    = if_id_q.pc;
  assign if_id_instr_o = if_id_q.instr;
  assign if_id_fault_o = if_id_q.fault;

endmodule
